// File: rtl/uart_tx_frame.sv
// ============================================================================
//  Module      : uart_tx_frame
//  Description : Parametrised UART transmitter. Sends a start bit, DATA_BITS
//                data bits LSB first, an optional parity bit and STOP_BITS
//                stop bits. Words arrive over a valid/ready handshake into a
//                1-entry holding buffer, so frames can run back-to-back.
//  Optional    : define UART_TX_PARITY_EN to add the parity bit
//                (sense selected by PARITY_ODD: 0 = even, 1 = odd).
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous active-high reset
//                tx_data  - word to send, sampled on handshake
//                tx_valid - tx_data is valid
//                tx_ready - holding buffer empty (registered)
//                tx_op    - serial line, registered, idle high
//                busy     - high for every cycle of every frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 100,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_op,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Reject illegal configurations at elaboration time.
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   buf_data;
    logic                   buf_full;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic                   par_bit;
`endif

    logic accept;
    logic baud_end;
    logic last_data;
    logic last_stop;
    logic frame_done;
    logic load;

    assign accept     = tx_valid && tx_ready;
    assign baud_end   = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    assign last_data  = (bit_cnt == BIT_W'(DATA_BITS - 1));
    // In STOP the bit counter counts stop bits instead of data bits.
    assign last_stop  = (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign frame_done = (state == STOP) && baud_end && last_stop;
    // Buffer drains into the shifter from IDLE, or straight at the end of
    // the last stop cycle so the next start bit follows with no gap.
    assign load       = buf_full && ((state == IDLE) || frame_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            buf_data  <= '0;
            buf_full  <= 1'b0;
            tx_ready  <= 1'b1;
            tx_op     <= 1'b1;
            busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            // Holding buffer. accept needs an empty buffer and load needs a
            // full one, so they never coincide.
            if (accept) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
                tx_ready <= 1'b0;
            end else if (load) begin
                buf_full <= 1'b0;
                tx_ready <= 1'b1;
            end

            if (load) begin
                state     <= START;
                shift_reg <= buf_data;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                tx_op     <= 1'b0;
                busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                par_bit   <= (^buf_data) ^ PAR_SENSE;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx_op <= 1'b1;
                        busy  <= 1'b0;
                    end
                    START: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            state    <= DATA;
                            tx_op    <= shift_reg[0];
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    DATA: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (last_data) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                tx_op   <= par_bit;
`else
                                state   <= STOP;
                                tx_op   <= 1'b1;
`endif
                            end else begin
                                bit_cnt   <= bit_cnt + BIT_W'(1);
                                shift_reg <= shift_reg >> 1;
                                // Next bit is shift_reg[1] before the shift lands.
                                tx_op     <= shift_reg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            state    <= STOP;
                            tx_op    <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (last_stop) begin
                                bit_cnt <= '0;
                                state   <= IDLE;
                                busy    <= 1'b0;
                                tx_op   <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx_op <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
